apb_interconnect: RTL and testbench
===================================

APB_INTERCONNECT -- requirements
Module: apb_interconnect

Interface
REQ-001 SHALL have parameter SLV0_BASE, default 34'h0_0000_0000, meaning base address of slave 0.
REQ-002 SHALL have parameter SLV0_MASK, default 34'h3_F000_0000, meaning address bits compared for slave 0.
REQ-003 SHALL have parameters SLV1_BASE/SLV1_MASK, defaults 34'h0_0200_0000/34'h3_FFFF_0000, meaning slave 1 region.
REQ-004 SHALL have parameters SLV2_BASE/SLV2_MASK, defaults 34'h0_1000_0000/34'h3_FFFF_F000, meaning slave 2 region.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning ACCESS wait limit.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 m_psel, m_penable, m_pwrite  input  1 each  master APB select, enable, direction.
REQ-009 m_paddr  input  34  master address; m_pwdata  input  32; m_pwstrb  input  4.
REQ-010 m_pready, m_pslverr  output  1 each; m_prdata  output  32  master response.
REQ-011 s_psel  output  3  one-hot slave select; s_penable, s_pwrite  output  1 each (shared).
REQ-012 s_paddr  output  34; s_pwdata  output  32; s_pwstrb  output  4 (shared, full address).
REQ-013 s_pready, s_pslverr  input  3 each; s_prdata  input  96 (slave n at bits 32n+31:32n).

Function
REQ-014 FSM states SHALL be IDLE, SETUP, ACCESS, RESP.
REQ-015 In IDLE, m_psel=1 and m_penable=0 SHALL latch m_paddr/m_pwrite/m_pwdata/m_pwstrb and the decode result.
REQ-016 Decode: slave n hits when (m_paddr & SLVn_MASK) == (SLVn_BASE & SLVn_MASK); overlapping hits SHALL select the lowest index.
REQ-017 IDLE with a hit SHALL go to SETUP; IDLE with no hit SHALL go directly to RESP with error.
REQ-018 SETUP SHALL drive s_psel[n]=1, s_penable=0 for exactly one cycle, then go to ACCESS.
REQ-019 ACCESS SHALL drive s_psel[n]=1, s_penable=1 until s_pready[n]=1, then latch s_prdata slice n and s_pslverr[n] and go to RESP.
REQ-020 RESP SHALL drive m_pready=1 for exactly one cycle with latched m_prdata/m_pslverr, then go to IDLE.
REQ-021 m_pready SHALL be 0 in every state other than RESP.
REQ-022 Unmapped access SHALL return m_pslverr=1, m_prdata=0; no s_psel bit asserts.
REQ-023 Write transfers SHALL return m_prdata=0.
REQ-024 Mapped latency, zero-wait slave: master SETUP at cycle 0; SETUP at cycle 1; ACCESS at cycle 2; m_pready=1 at cycle 3.
REQ-025 s_psel SHALL be at most one-hot at all times; s_paddr/s_pwrite/s_pwdata/s_pwstrb SHALL hold latched values from SETUP through ACCESS.
REQ-026 Master input changes after capture, including m_psel deasserting, SHALL be ignored until return to IDLE.
REQ-027 Back-to-back: a new master SETUP in the cycle after RESP SHALL be accepted from IDLE normally.
REQ-028 s_pready/s_pslverr of non-selected slaves SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, s_psel=0, s_penable=0, m_pready=0, m_pslverr=0, m_prdata=0, all latches and the timeout counter to 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer without a master response; the first master SETUP after rst falls SHALL be handled from IDLE.

Configuration
REQ-031 Macro APB_INTERCONNECT_TIMEOUT_EN defined: counter clears on ACCESS entry and increments each ACCESS cycle with s_pready[n]=0.
REQ-032 If the counter reaches TIMEOUT_CYCLES, the block SHALL drop s_psel/s_penable and go to RESP with m_pslverr=1, m_prdata=0.
REQ-033 Macro undefined: no counter is synthesised and ACCESS waits indefinitely for s_pready[n].

Verification
REQ-034 Read 0x0_0000_0010, slave 0 zero-wait, s_prdata[31:0]=0xDEADBEEF -> m_pready at cycle 3, m_prdata=0xDEADBEEF, m_pslverr=0.
REQ-035 Write 0x0_0200_0004, data 0x12345678, strb 0xF, slave 1 with 2 wait states -> s_psel=3'b010, s_pwdata=0x12345678, m_pready at cycle 5.
REQ-036 Read 0x0_2000_0000 (unmapped) -> s_psel stays 0, m_pready cycle after capture, m_pslverr=1, m_prdata=0.
REQ-037 TIMEOUT_EN, TIMEOUT_CYCLES=4, slave 2 never ready -> s_psel drops after 4 ACCESS cycles, m_pslverr=1; without macro, m_pready stays 0.
REQ-038 rst asserted during ACCESS on slave 0 -> s_psel=0, m_pready=0 same cycle; next read to slave 1 completes normally.

Source files
------------

// File: rtl/apb_interconnect.sv
// apb_interconnect: single APB master to three APB slaves with base/mask decode, lowest index wins on overlap.
// Optional ACCESS wait limit enabled by defining APB_INTERCONNECT_TIMEOUT_EN.
module apb_interconnect #(
    parameter logic [33:0] SLV0_BASE      = 34'h0_0000_0000,
    parameter logic [33:0] SLV0_MASK      = 34'h3_F000_0000,
    parameter logic [33:0] SLV1_BASE      = 34'h0_0200_0000,
    parameter logic [33:0] SLV1_MASK      = 34'h3_FFFF_0000,
    parameter logic [33:0] SLV2_BASE      = 34'h0_1000_0000,
    parameter logic [33:0] SLV2_MASK      = 34'h3_FFFF_F000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_psel,
    input  logic        m_penable,
    input  logic        m_pwrite,
    input  logic [33:0] m_paddr,
    input  logic [31:0] m_pwdata,
    input  logic [3:0]  m_pwstrb,
    output logic        m_pready,
    output logic        m_pslverr,
    output logic [31:0] m_prdata,
    output logic [2:0]  s_psel,
    output logic        s_penable,
    output logic        s_pwrite,
    output logic [33:0] s_paddr,
    output logic [31:0] s_pwdata,
    output logic [3:0]  s_pwstrb,
    input  logic [2:0]  s_pready,
    input  logic [2:0]  s_pslverr,
    input  logic [95:0] s_prdata
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t      state_q;
    logic [2:0]  sel_q, s_psel_q, hit, dec;
    logic        s_penable_q, write_q, m_pready_q, m_pslverr_q;
    logic [33:0] addr_q;
    logic [31:0] wdata_q, m_prdata_q, rdata;
    logic [3:0]  strb_q;
    logic        rdy, err, timeout;
    assign hit[0] = (m_paddr & SLV0_MASK) == (SLV0_BASE & SLV0_MASK);
    assign hit[1] = (m_paddr & SLV1_MASK) == (SLV1_BASE & SLV1_MASK);
    assign hit[2] = (m_paddr & SLV2_MASK) == (SLV2_BASE & SLV2_MASK);
    assign dec    = hit[0] ? 3'b001 : hit[1] ? 3'b010 : hit[2] ? 3'b100 : 3'b000;
    // Only the latched slave's response lines are looked at
    assign rdy   = |(s_pready & sel_q);
    assign err   = |(s_pslverr & sel_q);
    assign rdata = ({32{sel_q[0]}} & s_prdata[31:0])
                 | ({32{sel_q[1]}} & s_prdata[63:32])
                 | ({32{sel_q[2]}} & s_prdata[95:64]);
`ifdef APB_INTERCONNECT_TIMEOUT_EN
    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q;
    assign timeout = cnt_q == CNT_LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (state_q == SETUP) cnt_q <= '0;
        else if (state_q == ACCESS && !rdy) cnt_q <= cnt_q + 1'b1;
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            s_psel_q    <= '0;
            s_penable_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            m_pready_q  <= 1'b0;
            m_pslverr_q <= 1'b0;
            m_prdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (m_psel && !m_penable) begin
                    addr_q  <= m_paddr;
                    write_q <= m_pwrite;
                    wdata_q <= m_pwdata;
                    strb_q  <= m_pwstrb;
                    sel_q   <= dec;
                    if (|dec) begin
                        state_q  <= SETUP;
                        s_psel_q <= dec;
                    end else begin
                        state_q     <= RESP;
                        m_pready_q  <= 1'b1;
                        m_pslverr_q <= 1'b1;
                        m_prdata_q  <= '0;
                    end
                end
                SETUP: begin
                    state_q     <= ACCESS;
                    s_penable_q <= 1'b1;
                end
                ACCESS: if (rdy || timeout) begin
                    state_q     <= RESP;
                    s_psel_q    <= '0;
                    s_penable_q <= 1'b0;
                    m_pready_q  <= 1'b1;
                    m_pslverr_q <= rdy ? err : 1'b1;
                    m_prdata_q  <= (rdy && !write_q) ? rdata : '0;
                end
                RESP: begin
                    state_q    <= IDLE;
                    m_pready_q <= 1'b0;
                end
            endcase
        end
    end
    assign m_pready  = m_pready_q;
    assign m_pslverr = m_pslverr_q;
    assign m_prdata  = m_prdata_q;
    assign s_psel    = s_psel_q;
    assign s_penable = s_penable_q;
    assign s_pwrite  = write_q;
    assign s_paddr   = addr_q;
    assign s_pwdata  = wdata_q;
    assign s_pwstrb  = strb_q;
endmodule

// File: tb/tb_apb_interconnect.sv
// tb_apb_interconnect: directed checks of decode, latency, wait states, unmapped, timeout and reset.
// Main instance narrows slave 0 so slave 1 is reachable; a default-parameter instance shows lowest-index priority.
module tb_apb_interconnect;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_psel, m_penable, m_pwrite;
    logic [33:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pwstrb;
    logic [2:0]  s_pready, s_pslverr;
    logic [95:0] s_prdata;
    logic        m_pready, m_pslverr, s_penable, s_pwrite;
    logic [31:0] m_prdata, s_pwdata;
    logic [2:0]  s_psel, d_s_psel;
    logic [33:0] s_paddr;
    logic [3:0]  s_pwstrb;
    logic        unused_pready, unused_pslverr, unused_penable, unused_pwrite;
    logic [31:0] unused_prdata, unused_pwdata;
    logic [33:0] unused_paddr;
    logic [3:0]  unused_pwstrb;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_interconnect #(.SLV0_MASK(34'h3_FF00_0000), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb), .m_pready(m_pready),
        .m_pslverr(m_pslverr), .m_prdata(m_prdata), .s_psel(s_psel), .s_penable(s_penable),
        .s_pwrite(s_pwrite), .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb),
        .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata)
    );

    apb_interconnect u_def (
        .clk(clk), .rst(rst), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb), .m_pready(unused_pready),
        .m_pslverr(unused_pslverr), .m_prdata(unused_prdata), .s_psel(d_s_psel), .s_penable(unused_penable),
        .s_pwrite(unused_pwrite), .s_paddr(unused_paddr), .s_pwdata(unused_pwdata), .s_pwstrb(unused_pwstrb),
        .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [33:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        m_psel    = 1'b1;
        m_penable = 1'b0;
        m_paddr   = a;
        m_pwrite  = w;
        m_pwdata  = d;
        m_pwstrb  = s;
    endtask

    task automatic idle_master();
        m_psel    = 1'b0;
        m_penable = 1'b0;
    endtask

    initial begin
        idle_master();
        m_pwrite  = 1'b0;
        m_paddr   = '0;
        m_pwdata  = '0;
        m_pwstrb  = '0;
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        repeat (2) tick();
        check("rst_pready", m_pready, 0);
        check("rst_psel", s_psel, 0);
        check("rst_penable", s_penable, 0);
        check("rst_pslverr", m_pslverr, 0);
        check("rst_prdata", m_prdata, 0);
        rst = 1'b0;
        // zero-wait read of slave 0, master inputs scrambled after capture
        tick();
        s_pready = 3'b111;
        s_prdata[31:0] = 32'hDEADBEEF;
        setup(34'h0_0000_0010, 1'b0, 32'h0, 4'h0);
        tick();
        check("rd0_c1_psel", s_psel, 3'b001);
        check("rd0_c1_penable", s_penable, 0);
        check("rd0_c1_pready", m_pready, 0);
        m_penable = 1'b1;
        m_paddr   = 34'h3_FFFF_FFFF;
        m_pwrite  = 1'b1;
        tick();
        check("rd0_c2_psel", s_psel, 3'b001);
        check("rd0_c2_penable", s_penable, 1);
        check("rd0_c2_paddr", s_paddr, 34'h10);
        check("rd0_c2_pwrite", s_pwrite, 0);
        check("rd0_c2_pready", m_pready, 0);
        tick();
        check("rd0_c3_pready", m_pready, 1);
        check("rd0_c3_prdata", m_prdata, 32'hDEADBEEF);
        check("rd0_c3_pslverr", m_pslverr, 0);
        check("rd0_c3_psel", s_psel, 0);
        check("rd0_c3_penable", s_penable, 0);
        idle_master();
        tick();
        check("rd0_c4_pready", m_pready, 0);
        // write to slave 1 with two wait states; slave 0 ready/error lines must be ignored
        s_pready  = 3'b001;
        s_pslverr = 3'b001;
        s_prdata[63:32] = 32'hCAFEF00D;
        setup(34'h0_0200_0004, 1'b1, 32'h12345678, 4'hF);
        tick();
        check("wr1_c1_psel", s_psel, 3'b010);
        check("def_priority_psel", d_s_psel, 3'b001);
        check("wr1_c1_pwdata", s_pwdata, 32'h12345678);
        check("wr1_c1_pwrite", s_pwrite, 1);
        check("wr1_c1_pwstrb", s_pwstrb, 4'hF);
        check("wr1_c1_paddr", s_paddr, 34'h0_0200_0004);
        m_penable = 1'b1;
        tick();
        check("wr1_c2_penable", s_penable, 1);
        check("wr1_c2_pready", m_pready, 0);
        tick();
        check("wr1_c3_pready", m_pready, 0);
        tick();
        check("wr1_c4_pready", m_pready, 0);
        check("wr1_c4_psel", s_psel, 3'b010);
        s_pready = 3'b011;
        tick();
        check("wr1_c5_pready", m_pready, 1);
        check("wr1_c5_prdata", m_prdata, 0);
        check("wr1_c5_pslverr", m_pslverr, 0);
        check("wr1_c5_psel", s_psel, 0);
        // back-to-back unmapped read issued in the RESP cycle
        s_pslverr = '0;
        s_prdata  = {3{32'h5555AAAA}};
        setup(34'h0_2000_0000, 1'b0, 32'h0, 4'h0);
        tick();
        check("um_c0_pready", m_pready, 0);
        check("um_c0_psel", s_psel, 0);
        tick();
        check("um_c1_pready", m_pready, 1);
        check("um_c1_pslverr", m_pslverr, 1);
        check("um_c1_prdata", m_prdata, 0);
        check("um_c1_psel", s_psel, 0);
        idle_master();
        tick();
        check("um_c2_pready", m_pready, 0);
        // slave 2 never ready
        s_pready = 3'b011;
        s_prdata[95:64] = 32'hFFFFFFFF;
        setup(34'h0_1000_0100, 1'b0, 32'h0, 4'h0);
        tick();
        check("to_c1_psel", s_psel, 3'b100);
        m_penable = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("to_access_psel", s_psel, 3'b100);
            check("to_access_pready", m_pready, 0);
        end
        tick();
`ifdef APB_INTERCONNECT_TIMEOUT_EN
        check("to_c6_psel", s_psel, 0);
        check("to_c6_penable", s_penable, 0);
        check("to_c6_pready", m_pready, 1);
        check("to_c6_pslverr", m_pslverr, 1);
        check("to_c6_prdata", m_prdata, 0);
`else
        check("to_c6_psel", s_psel, 3'b100);
        check("to_c6_pready", m_pready, 0);
        repeat (10) tick();
        check("to_late_psel", s_psel, 3'b100);
        check("to_late_pready", m_pready, 0);
`endif
        idle_master();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // reset during ACCESS on slave 0
        tick();
        s_pready = '0;
        setup(34'h0_0000_0040, 1'b0, 32'h0, 4'h0);
        tick();
        m_penable = 1'b1;
        tick();
        check("rr_c2_psel", s_psel, 3'b001);
        check("rr_c2_penable", s_penable, 1);
        rst = 1'b1;
        #1;
        check("rr_async_psel", s_psel, 0);
        check("rr_async_penable", s_penable, 0);
        check("rr_async_pready", m_pready, 0);
        idle_master();
        tick();
        rst = 1'b0;
        tick();
        check("rr_post_pready", m_pready, 0);
        // read slave 1 after reset
        s_pready = 3'b010;
        s_prdata[63:32] = 32'hA5A51234;
        setup(34'h0_0200_0008, 1'b0, 32'h0, 4'h0);
        tick();
        check("rd1_c1_psel", s_psel, 3'b010);
        m_penable = 1'b1;
        tick();
        check("rd1_c2_pready", m_pready, 0);
        tick();
        check("rd1_c3_pready", m_pready, 1);
        check("rd1_c3_prdata", m_prdata, 32'hA5A51234);
        check("rd1_c3_pslverr", m_pslverr, 0);
        // back-to-back read of slave 2 reporting an error
        s_pready  = 3'b100;
        s_pslverr = 3'b100;
        s_prdata[95:64] = 32'h0BAD0BAD;
        setup(34'h0_1000_0200, 1'b0, 32'h0, 4'h0);
        tick();
        check("rd2_c0_pready", m_pready, 0);
        tick();
        check("rd2_c1_psel", s_psel, 3'b100);
        m_penable = 1'b1;
        tick();
        tick();
        check("rd2_c3_pready", m_pready, 1);
        check("rd2_c3_pslverr", m_pslverr, 1);
        check("rd2_c3_prdata", m_prdata, 32'h0BAD0BAD);
        idle_master();
        tick();
        check("rd2_c4_pready", m_pready, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
